// File: rtl/mmu_feed_scheduler.sv
// Sequencer for one 2x2 output-stationary matrix multiply.
// Fetches operands, feeds them skewed, drains the array and streams the results.
module mmu_feed_scheduler #(
    parameter int DATA_W       = 8,
    parameter int ACC_W        = 18,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 wm_rd_en,
    output logic [2:0]           wm_rd_addr,
    input  logic [DATA_W-1:0]    wm_rd_data,
    output logic                 mmu_clear,
    output logic                 mmu_en,
    output logic [DATA_W-1:0]    mmu_a0,
    output logic [DATA_W-1:0]    mmu_a1,
    output logic [DATA_W-1:0]    mmu_b0,
    output logic [DATA_W-1:0]    mmu_b1,
    input  logic [4*ACC_W-1:0]   mmu_c,
    output logic [ACC_W-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready
);

    typedef enum logic [2:0] {
        IDLE, FETCH, CLEAR, FEED, DRAIN, CAPTURE, WB
    } state_t;

    localparam logic [3:0] FETCH_LAST = 4'd8;
    localparam logic [3:0] FEED_LAST  = 4'd2;
    localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

    state_t state, state_n;
    logic [3:0] cnt, cnt_n, cap_idx;
    logic [1:0] idx, idx_n;
    logic done_n;

    logic [DATA_W-1:0] op [8];
    logic [ACC_W-1:0]  res [4];

    logic              rd_en_d, clear_d, en_d, valid_d, busy_d;
    logic [2:0]        rd_addr_d;
    logic [DATA_W-1:0] a0_d, a1_d, b0_d, b1_d;
    logic [ACC_W-1:0]  data_d;

    // Read data returns one cycle late, so it belongs to the previous address.
    assign cap_idx = cnt - 4'd1;

    // Next-state sequencing: state, step counter and writeback index.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = FETCH;
                    cnt_n   = 4'd0;
                end
            end
            FETCH: begin
                if (cnt == FETCH_LAST) begin
                    state_n = CLEAR;
                    cnt_n   = 4'd0;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            CLEAR: begin
                state_n = FEED;
                cnt_n   = 4'd0;
            end
            FEED: begin
                if (cnt == FEED_LAST) begin
                    state_n = DRAIN;
                    cnt_n   = 4'd0;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            DRAIN: begin
                if (cnt == DRAIN_LAST) begin
                    state_n = CAPTURE;
                    cnt_n   = 4'd0;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            CAPTURE: begin
                state_n = WB;
                idx_n   = 2'd0;
            end
            WB: begin
                if (out_valid && out_ready) begin
                    if (idx == 2'd3) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        idx_n = idx + 2'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Output values for the coming cycle, decoded from the next state.
    always_comb begin
        rd_en_d   = 1'b0;
        rd_addr_d = 3'd0;
        clear_d   = 1'b0;
        en_d      = 1'b0;
        valid_d   = 1'b0;
        a0_d      = '0;
        a1_d      = '0;
        b0_d      = '0;
        b1_d      = '0;
        data_d    = '0;
        busy_d    = (state_n != IDLE);
        unique case (state_n)
            FETCH: begin
                rd_en_d   = (cnt_n < FETCH_LAST);
                rd_addr_d = cnt_n[2:0];
            end
            CLEAR: clear_d = 1'b1;
            FEED: begin
                en_d = 1'b1;
                if (cnt_n == 4'd0) begin
                    a0_d = op[0];
                    b0_d = op[4];
                end else if (cnt_n == 4'd1) begin
                    a0_d = op[1];
                    a1_d = op[2];
                    b0_d = op[6];
                    b1_d = op[5];
                end else begin
                    a1_d = op[3];
                    b1_d = op[7];
                end
            end
            DRAIN: en_d = 1'b1;
            WB: begin
                valid_d = 1'b1;
                // First result comes straight off the array while it is latched.
                if (state == CAPTURE) data_d = mmu_c[ACC_W-1:0];
                else                  data_d = res[idx_n];
            end
            default: ;
        endcase
    end

    // State, buffers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            done       <= 1'b0;
            busy       <= 1'b0;
            wm_rd_en   <= 1'b0;
            wm_rd_addr <= '0;
            mmu_clear  <= 1'b0;
            mmu_en     <= 1'b0;
            mmu_a0     <= '0;
            mmu_a1     <= '0;
            mmu_b0     <= '0;
            mmu_b1     <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            for (int i = 0; i < 8; i++) op[i] <= '0;
            for (int i = 0; i < 4; i++) res[i] <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            done       <= done_n;
            busy       <= busy_d;
            wm_rd_en   <= rd_en_d;
            wm_rd_addr <= rd_addr_d;
            mmu_clear  <= clear_d;
            mmu_en     <= en_d;
            mmu_a0     <= a0_d;
            mmu_a1     <= a1_d;
            mmu_b0     <= b0_d;
            mmu_b1     <= b1_d;
            out_valid  <= valid_d;
            out_data   <= data_d;
            if (state == FETCH && cnt != 4'd0)
                op[cap_idx[2:0]] <= wm_rd_data;
            if (state == CAPTURE)
                for (int i = 0; i < 4; i++)
                    res[i] <= mmu_c[i*ACC_W +: ACC_W];
        end
    end

endmodule

// File: tb/tb_mmu_feed_scheduler.sv
// Bench for mmu_feed_scheduler: memory and MMU models,
// a cycle-table reference model and directed jobs.
module tb_mmu_feed_scheduler;

    localparam int DW = 8;
    localparam int AW = 18;
    localparam int DC = 2;

    logic          clk, rst_n, start;
    logic          busy, done, wm_rd_en;
    logic [2:0]    wm_rd_addr;
    logic [DW-1:0] wm_rd_data;
    logic          mmu_clear, mmu_en;
    logic [DW-1:0] mmu_a0, mmu_a1, mmu_b0, mmu_b1;
    logic [4*AW-1:0] mmu_c;
    logic [AW-1:0] out_data;
    logic          out_valid, out_ready;

    mmu_feed_scheduler #(.DATA_W(DW), .ACC_W(AW), .DRAIN_CYCLES(DC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .wm_rd_en(wm_rd_en), .wm_rd_addr(wm_rd_addr), .wm_rd_data(wm_rd_data),
        .mmu_clear(mmu_clear), .mmu_en(mmu_en),
        .mmu_a0(mmu_a0), .mmu_a1(mmu_a1), .mmu_b0(mmu_b0), .mmu_b1(mmu_b1),
        .mmu_c(mmu_c), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int ma [4];
    int mb [4];
    logic [DW-1:0] mem [8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read weight memory.
    initial wm_rd_data = '0;
    always @(posedge clk) if (wm_rd_en) wm_rd_data <= mem[wm_rd_addr];

    // Behavioural 2x2 output-stationary systolic array.
    logic [AW-1:0] acc [4];
    logic [DW-1:0] ar0, ar1, br0, br1;
    initial begin
        for (int i = 0; i < 4; i++) acc[i] = '0;
        ar0 = '0; ar1 = '0; br0 = '0; br1 = '0;
    end
    always @(posedge clk) begin
        if (mmu_clear) begin
            for (int i = 0; i < 4; i++) acc[i] <= '0;
            ar0 <= '0; ar1 <= '0; br0 <= '0; br1 <= '0;
        end else if (mmu_en) begin
            acc[0] <= acc[0] + AW'(mmu_a0) * AW'(mmu_b0);
            acc[1] <= acc[1] + AW'(ar0) * AW'(mmu_b1);
            acc[2] <= acc[2] + AW'(mmu_a1) * AW'(br0);
            acc[3] <= acc[3] + AW'(ar1) * AW'(br1);
            ar0 <= mmu_a0; br0 <= mmu_b0;
            ar1 <= mmu_a1; br1 <= mmu_b1;
        end
    end
    assign mmu_c = {acc[3], acc[2], acc[1], acc[0]};

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int cres(input int i);
        case (i)
            0: return ma[0] * mb[0] + ma[1] * mb[2];
            1: return ma[0] * mb[1] + ma[1] * mb[3];
            2: return ma[2] * mb[0] + ma[3] * mb[2];
            default: return ma[2] * mb[1] + ma[3] * mb[3];
        endcase
    endfunction

    task automatic load(input int a0, a1, a2, a3, b0, b1, b2, b3);
        ma[0] = a0; ma[1] = a1; ma[2] = a2; ma[3] = a3;
        mb[0] = b0; mb[1] = b1; mb[2] = b2; mb[3] = b3;
        for (int i = 0; i < 4; i++) begin
            mem[i]   = DW'(ma[i]);
            mem[i+4] = DW'(mb[i]);
        end
    endtask

    // Reference model: job timeline by cycle number since start.
    bit m_run = 0;
    bit m_done = 0;
    int m_t = 0;
    int m_idx = 0;
    always @(negedge clk) begin
        int e_rd, e_addr, e_clr, e_en, e_a0, e_a1, e_b0, e_b1;
        int e_val, e_data, e_busy, e_done;
        bit care_addr, care_ops, care_data;
        bit nd;
        if (!rst_n) begin
            m_run = 0; m_done = 0;
        end
        e_rd = 0; e_addr = 0; e_clr = 0; e_en = 0;
        e_a0 = 0; e_a1 = 0; e_b0 = 0; e_b1 = 0;
        e_val = 0; e_data = 0;
        e_busy = m_run ? 1 : 0;
        e_done = m_done ? 1 : 0;
        care_addr = !m_run; care_ops = !m_run; care_data = !m_run;
        if (m_run) begin
            if (m_t <= 8) begin
                e_rd = 1; e_addr = m_t - 1; care_addr = 1;
            end else if (m_t == 9) begin
                care_addr = 0;
            end else if (m_t == 10) begin
                e_clr = 1; care_ops = 1;
            end else if (m_t == 11) begin
                e_en = 1; care_ops = 1; e_a0 = ma[0]; e_b0 = mb[0];
            end else if (m_t == 12) begin
                e_en = 1; care_ops = 1;
                e_a0 = ma[1]; e_a1 = ma[2]; e_b0 = mb[2]; e_b1 = mb[1];
            end else if (m_t == 13) begin
                e_en = 1; care_ops = 1; e_a1 = ma[3]; e_b1 = mb[3];
            end else if (m_t <= 13 + DC) begin
                e_en = 1; care_ops = 1;
            end else if (m_t >= 15 + DC) begin
                e_val = 1; e_data = cres(m_idx); care_data = 1;
            end
        end
        chk($sformatf("busy t=%0d", m_t), 32'(busy), e_busy);
        chk($sformatf("done t=%0d", m_t), 32'(done), e_done);
        chk($sformatf("rd_en t=%0d", m_t), 32'(wm_rd_en), e_rd);
        chk($sformatf("clear t=%0d", m_t), 32'(mmu_clear), e_clr);
        chk($sformatf("en t=%0d", m_t), 32'(mmu_en), e_en);
        chk($sformatf("valid t=%0d", m_t), 32'(out_valid), e_val);
        if (care_addr)
            chk($sformatf("addr t=%0d", m_t), 32'(wm_rd_addr), e_addr);
        if (care_ops) begin
            chk($sformatf("a0 t=%0d", m_t), 32'(mmu_a0), e_a0);
            chk($sformatf("a1 t=%0d", m_t), 32'(mmu_a1), e_a1);
            chk($sformatf("b0 t=%0d", m_t), 32'(mmu_b0), e_b0);
            chk($sformatf("b1 t=%0d", m_t), 32'(mmu_b1), e_b1);
        end
        if (care_data)
            chk($sformatf("data t=%0d idx=%0d", m_t, m_idx),
                32'(out_data), e_data);
        nd = 0;
        if (rst_n) begin
            if (m_run) begin
                if (m_t >= 15 + DC && out_ready) begin
                    if (m_idx == 3) begin
                        m_run = 0; nd = 1;
                    end else begin
                        m_idx++;
                    end
                end
                m_t++;
            end else if (start) begin
                m_run = 1; m_t = 1; m_idx = 0;
            end
        end
        m_done = nd;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        while (!done && cyc < budget) begin
            tick();
            cyc++;
        end
        if (!done) chk("done timeout", 32'(done), 1);
    endtask

    initial begin
        int c;
        rst_n = 1'b0; start = 1'b0; out_ready = 1'b1;
        load(1, 2, 3, 4, 5, 6, 7, 8);
        repeat (3) tick();
        chk("reset busy", 32'(busy), 0);
        chk("reset valid", 32'(out_valid), 0);
        chk("reset rd_en", 32'(wm_rd_en), 0);
        rst_n = 1'b1;
        tick();

        // Job 1: basic multiply, stray start on cycle 5.
        start_job();
        chk("j1 c1 rd_en", 32'(wm_rd_en), 1);
        chk("j1 c1 addr", 32'(wm_rd_addr), 0);
        repeat (4) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("j1 c6 addr", 32'(wm_rd_addr), 5);
        repeat (4) tick();
        chk("j1 c10 clear", 32'(mmu_clear), 1);
        tick();
        chk("j1 c11 clear", 32'(mmu_clear), 0);
        chk("j1 c11 a0", 32'(mmu_a0), 1);
        chk("j1 c11 b0", 32'(mmu_b0), 5);
        tick();
        chk("j1 c12 a0", 32'(mmu_a0), 2);
        chk("j1 c12 a1", 32'(mmu_a1), 3);
        chk("j1 c12 b0", 32'(mmu_b0), 7);
        chk("j1 c12 b1", 32'(mmu_b1), 6);
        tick();
        chk("j1 c13 a0", 32'(mmu_a0), 0);
        chk("j1 c13 a1", 32'(mmu_a1), 4);
        chk("j1 c13 b0", 32'(mmu_b0), 0);
        chk("j1 c13 b1", 32'(mmu_b1), 8);
        repeat (4) tick();
        chk("j1 c17 data", 32'(out_data), 19);
        tick();
        chk("j1 c18 data", 32'(out_data), 22);
        tick();
        chk("j1 c19 data", 32'(out_data), 43);
        tick();
        chk("j1 c20 data", 32'(out_data), 50);
        chk("j1 c20 done", 32'(done), 0);
        tick();
        chk("j1 c21 done", 32'(done), 1);
        chk("j1 c21 busy", 32'(busy), 0);

        // Job 2: restart in the done cycle, then backpressure at idx 1.
        start_job();
        chk("j2 c1 rd_en", 32'(wm_rd_en), 1);
        chk("j2 c1 done", 32'(done), 0);
        repeat (16) tick();
        chk("j2 c17 data", 32'(out_data), 19);
        tick();
        out_ready = 1'b0;
        chk("j2 c18 data", 32'(out_data), 22);
        tick();
        chk("j2 c19 data", 32'(out_data), 22);
        tick();
        chk("j2 c20 data", 32'(out_data), 22);
        chk("j2 c20 valid", 32'(out_valid), 1);
        tick();
        out_ready = 1'b1;
        chk("j2 c21 data", 32'(out_data), 22);
        tick();
        chk("j2 c22 data", 32'(out_data), 43);
        tick();
        chk("j2 c23 data", 32'(out_data), 50);
        chk("j2 c23 done", 32'(done), 0);
        tick();
        chk("j2 c24 done", 32'(done), 1);
        tick();

        // Job 3: maximum operands.
        load(255, 255, 255, 255, 255, 255, 255, 255);
        start_job();
        repeat (16) tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("j3 max r%0d", i), 32'(out_data), 130050);
            tick();
        end
        chk("j3 c21 done", 32'(done), 1);
        tick();

        // Job 4: reset in the middle of FEED.
        load(9, 0, 200, 13, 17, 250, 3, 1);
        start_job();
        repeat (11) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("rst mid en", 32'(mmu_en), 0);
        chk("rst mid busy", 32'(busy), 0);
        chk("rst mid a1", 32'(mmu_a1), 0);
        chk("rst mid b1", 32'(mmu_b1), 0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (30) tick();

        // Job 5: clean run after the abandoned job.
        start_job();
        repeat (16) tick();
        chk("j5 c17 data", 32'(out_data), 153);
        tick();
        chk("j5 c18 data", 32'(out_data), 2250);
        tick();
        chk("j5 c19 data", 32'(out_data), 3439);
        tick();
        chk("j5 c20 data", 32'(out_data), 50013);
        wait_done(40, c);
        chk("j5 done delay", 32'(c), 1);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mmu_feed_scheduler.md
Name: mmu_feed_scheduler

Overview:
- Sequences one 2x2 matrix multiply after the host has filled weight memory.
- Fetches 8 operands from weight memory and clears the 2x2 output-stationary systolic MMU.
- Feeds the operands with diagonal skew, drains the array, captures the 4 results and streams them to the host over a valid/ready port.
- Sits between weight memory, the MMU and the host writeback path; the top-level control FSM drives it with start and waits for done.

Parameters:
- DATA_W, 8: operand width, unsigned.
- ACC_W, 18: MMU result width per PE.
- DRAIN_CYCLES, 2: zero-operand cycles after feed, with mmu_en still high, so PE(1,1) completes. Legal range 1..7.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  begin operation; sampled only in IDLE.
- busy  out  1  high in every non-IDLE state.
- done  out  1  one-cycle pulse after the final result handshake.
- wm_rd_en  out  1  weight-memory read strobe.
- wm_rd_addr  out  3  read address. 0..3 = A00,A01,A10,A11; 4..7 = B00,B01,B10,B11 (row-major).
- wm_rd_data  in  DATA_W  read data, valid the cycle after wm_rd_en.
- mmu_clear  out  1  zero all PE accumulators.
- mmu_en  out  1  MMU advance/accumulate enable.
- mmu_a0, mmu_a1  out  DATA_W each  row-0 / row-1 left-edge operands.
- mmu_b0, mmu_b1  out  DATA_W each  col-0 / col-1 top-edge operands.
- mmu_c  in  4*ACC_W  results, packed {C11,C10,C01,C00}, C00 in LSBs.
- out_data  out  ACC_W  result to host.
- out_valid  out  1  out_data valid.
- out_ready  in  1  host accepts.

Behaviour:
- Reset (asynchronous, any state): state = IDLE; all outputs 0; counters and operand/result buffers cleared. Reset mid-operation abandons the job; no done is produced.
- States: IDLE -> FETCH -> CLEAR -> FEED -> DRAIN -> CAPTURE -> WB -> IDLE.
- Cycle numbering: "cycle n" = n cycles after the clock edge that samples start=1 in IDLE.
- IDLE:
  - All outputs 0.
  - start=1 -> FETCH.
- FETCH (cycles 1..9):
  - Cycles 1..8: wm_rd_en=1, wm_rd_addr = 0..7.
  - Cycles 2..9: wm_rd_data is captured into operand slot (previous cycle's address).
  - Cycle 9: wm_rd_en=0, last capture.
  - -> CLEAR.
- CLEAR (cycle 10): mmu_clear=1, mmu_en=0, operands 0.
- FEED (cycles 11..13): mmu_en=1; per feed step k:
  - k0: a0=A00, a1=0, b0=B00, b1=0.
  - k1: a0=A01, a1=A10, b0=B10, b1=B01.
  - k2: a0=0, a1=A11, b0=0, b1=B11.
- DRAIN: DRAIN_CYCLES cycles, mmu_en=1, all operands 0.
- CAPTURE: 1 cycle, mmu_en=0; mmu_c is latched into the 4-entry result buffer.
- WB:
  - out_valid=1, out_data = buffer[idx], idx order C00, C01, C10, C11.
  - idx advances only on out_valid && out_ready.
  - out_data is held stable while out_ready=0.
  - The handshake on idx=3 -> IDLE.
- done: registered; =1 in the cycle after the final handshake (state already IDLE), else 0.
- busy: registered from state; =1 from cycle 1 to the cycle of the final handshake.
- start while busy: ignored, no queuing. start=1 in the done cycle starts a new job, since the block is in IDLE.
- Default timing (DRAIN_CYCLES=2, out_ready tied 1): CAPTURE cycle 16; out_valid cycles 17..20; done cycle 21.
- Arithmetic: this block performs none. Results are forwarded bit-exact; ACC_W=18 holds the 2*255*255 maximum.
- Outputs are registered; no combinational path from out_ready to out_valid or out_data.

Test Plan:
- Basic multiply: A=[[1,2],[3,4]], B=[[5,6],[7,8]], behavioural MMU model, out_ready=1 -> out_data 19, 22, 43, 50 on cycles 17..20; done=1 on cycle 21 only.
- Feed skew: same job -> cycle 12 shows a0=2, a1=3, b0=7, b1=6; cycle 13 shows a0=0, a1=4, b0=0, b1=8; mmu_clear=1 on cycle 10 only.
- Backpressure: out_ready low for 3 cycles at idx=1 -> out_data held at 22 with out_valid=1; completes in order; done 3 cycles later (cycle 24).
- Start while busy: start pulse on cycle 5 -> ignored, no address restart; single done. Then start in the done cycle -> wm_rd_en is 1 on the next cycle.
- Max operands: all elements 255 -> four results of 130050, no truncation.
- Reset during FEED (cycle 12): rst_n low mid-cycle -> outputs 0 immediately; no done. A following start runs a clean job with correct results.
